// File: rtl/fifo_rr_write_arbiter_pkg.sv
// rtl/fifo_rr_write_arbiter_pkg.sv - shared types, defaults and width helpers for the FIFO write arbiter
//
// Package fifo_arb_pkg: arbiter state encoding, default parameter values,
// and helpers that derive index/occupancy widths from NUM_REQ and DEPTH.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        STALL = 2'd2
    } arb_state_t;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_DEPTH     = 8;
    localparam int DEF_BURST_MAX = 4;
    localparam int DEF_AF_LEVEL  = 6;

    // Producer index width; at least one bit even for degenerate counts.
    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Occupancy needs to represent 0..DEPTH inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Burst counter must hold BURST_MAX itself (value after the last write).
    function automatic int cnt_width(input int burst_max);
        return $clog2(burst_max) + 1;
    endfunction

endpackage

// File: rtl/fifo_rr_write_arbiter_if.sv
// rtl/fifo_rr_write_arbiter_if.sv - producer and FIFO write-side bundle for the arbiter
//
// Signals:
//   req_valid/req_data/req_ready : NUM_REQ producers, producer i data at [i*DATA_W +: DATA_W]
//   fifo_wr_en/fifo_data_in      : FIFO write port
//   fifo_full                    : FIFO full flag
//   fifo_rd_en/fifo_empty        : FIFO read side, observed only
// Modports: master = arbiter side, slave = producers/FIFO side.
interface fifo_rr_write_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fifo_wr_en;
    logic [DATA_W-1:0]         fifo_data_in;
    logic                      fifo_full;
    logic                      fifo_rd_en;
    logic                      fifo_empty;

    modport master (
        input  req_valid, req_data, fifo_full, fifo_rd_en, fifo_empty,
        output req_ready, fifo_wr_en, fifo_data_in
    );

    modport slave (
        output req_valid, req_data, fifo_full, fifo_rd_en, fifo_empty,
        input  req_ready, fifo_wr_en, fifo_data_in
    );
endinterface

// File: rtl/fifo_rr_write_arbiter_rr_pick.sv
// rtl/fifo_rr_write_arbiter_rr_pick.sv - combinational round-robin priority encoder
//
// Ports:
//   req  in  NUM_REQ  request vector
//   last in  ID_W     most recently served index; search starts at last+1
//   hit  out 1        any request set
//   idx  out ID_W     first set request at or after last+1, wrapping
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]           req,
    input  logic [id_width(NUM_REQ)-1:0] last,
    output logic                         hit,
    output logic [id_width(NUM_REQ)-1:0] idx
);
    localparam int ID_W = id_width(NUM_REQ);

    // Walk distances from farthest to nearest so the nearest hit overrides.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(last) + k) % NUM_REQ]) begin
                hit = 1'b1;
                idx = ID_W'((int'(last) + k) % NUM_REQ);
            end
        end
    end
endmodule

// File: rtl/fifo_rr_write_arbiter.sv
// rtl/fifo_rr_write_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   bus          : producer handshakes and FIFO write/read-observe signals (master modport)
//   grant_valid  : a producer owns the write port
//   grant_id     : owning producer index
//   occupancy    : locally tracked FIFO fill level, 0..DEPTH
//   almost_full  : registered, occupancy >= AF_LEVEL
module fifo_rr_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int BURST_MAX = DEF_BURST_MAX,
    parameter int AF_LEVEL  = DEF_AF_LEVEL
) (
    input  logic                          clk,
    input  logic                          rst,
    fifo_rr_write_arbiter_if.master       bus,
    output logic                          grant_valid,
    output logic [id_width(NUM_REQ)-1:0]  grant_id,
    output logic [occ_width(DEPTH)-1:0]   occupancy,
    output logic                          almost_full
);
    localparam int ID_W  = id_width(NUM_REQ);
    localparam int OCC_W = occ_width(DEPTH);
    localparam int CNT_W = cnt_width(BURST_MAX);

    arb_state_t        state_q, state_d;
    logic              grant_valid_d;
    logic [ID_W-1:0]   grant_id_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [OCC_W-1:0]  occ_d;

    logic              pick_hit;
    logic [ID_W-1:0]   pick_idx;

    logic [NUM_REQ-1:0] ready;
    logic               wr_en;
    logic [DATA_W-1:0]  data_in;
    logic               owner_valid;
    logic               rd;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req  (bus.req_valid),
        .last (last_grant_q),
        .hit  (pick_hit),
        .idx  (pick_idx)
    );

    assign owner_valid      = bus.req_valid[grant_id];
    assign bus.req_ready    = ready;
    assign bus.fifo_wr_en   = wr_en;
    assign bus.fifo_data_in = data_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_valid  <= 1'b0;
            grant_id     <= '0;
            burst_cnt_q  <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            occupancy    <= '0;
            almost_full  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_valid  <= grant_valid_d;
            grant_id     <= grant_id_d;
            burst_cnt_q  <= burst_cnt_d;
            last_grant_q <= last_grant_d;
            occupancy    <= occ_d;
            almost_full  <= (occ_d >= OCC_W'(AF_LEVEL));
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_valid_d = grant_valid;
        grant_id_d    = grant_id;
        burst_cnt_d   = burst_cnt_q;
        last_grant_d  = last_grant_q;
        ready         = '0;
        wr_en         = 1'b0;
        data_in       = '0;

        // Data path follows the owner for the whole grant, stalls included.
        if (grant_valid) begin
            data_in = bus.req_data[int'(grant_id)*DATA_W +: DATA_W];
        end

        case (state_q)
            IDLE: begin
                if (pick_hit) begin
                    grant_id_d    = pick_idx;
                    grant_valid_d = 1'b1;
                    burst_cnt_d   = '0;
                    state_d       = BURST;
                end
            end
            BURST: begin
                ready[grant_id] = !bus.fifo_full;
                wr_en           = owner_valid & !bus.fifo_full;
                if (!owner_valid) begin
                    last_grant_d  = grant_id;
                    grant_valid_d = 1'b0;
                    state_d       = IDLE;
                end else if (bus.fifo_full) begin
                    state_d = STALL;
                end else begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    if (burst_cnt_q == CNT_W'(BURST_MAX - 1)) begin
                        last_grant_d  = grant_id;
                        grant_valid_d = 1'b0;
                        state_d       = IDLE;
                    end
                end
            end
            STALL: begin
                if (!owner_valid) begin
                    last_grant_d  = grant_id;
                    grant_valid_d = 1'b0;
                    state_d       = IDLE;
                end else if (!bus.fifo_full) begin
                    state_d = BURST;
                end
            end
            default: begin
                state_d       = IDLE;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    // Reads against an empty FIFO are ignored; both saturation ends hold.
    always_comb begin
        rd    = bus.fifo_rd_en & !bus.fifo_empty;
        occ_d = occupancy;
        if (wr_en && !rd && occupancy != OCC_W'(DEPTH)) begin
            occ_d = occupancy + OCC_W'(1);
        end else if (rd && !wr_en && occupancy != '0) begin
            occ_d = occupancy - OCC_W'(1);
        end
    end
endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// tb/tb_fifo_rr_write_arbiter.sv - directed self-checking bench for fifo_rr_write_arbiter
module tb_fifo_rr_write_arbiter;
    import fifo_arb_pkg::*;

    logic       clk;
    logic       rst;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic [3:0] occupancy;
    logic       almost_full;

    fifo_rr_write_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

    fifo_rr_write_arbiter #(
        .NUM_REQ   (4),
        .DATA_W    (8),
        .DEPTH     (8),
        .BURST_MAX (4),
        .AF_LEVEL  (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .occupancy   (occupancy),
        .almost_full (almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] pmem [4][32];
    int         phead [4];
    int         ptail [4];
    bit         pen   [4];

    logic [7:0] log_d [$];
    int         log_g [$];
    int         log_c [$];

    logic       s_wr;
    logic [7:0] s_data;
    logic [3:0] s_ready;
    logic       s_gv;
    logic [1:0] s_gid;
    int         s_state;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (pen[i] && phead[i] < ptail[i]) begin
                bus.req_valid[i]       = 1'b1;
                bus.req_data[i*8 +: 8] = pmem[i][phead[i]];
            end else begin
                bus.req_valid[i]       = 1'b0;
                bus.req_data[i*8 +: 8] = 8'h00;
            end
        end
    endtask

    task automatic load(input int p, input int n, input int base, input bit en);
        for (int k = 0; k < n; k++) pmem[p][k] = 8'(base + k);
        phead[p] = 0;
        ptail[p] = n;
        pen[p]   = en;
    endtask

    // Sample mid-cycle, then commit any accepted word after the edge and redrive.
    task automatic tick();
        @(negedge clk);
        s_wr    = bus.fifo_wr_en;
        s_data  = bus.fifo_data_in;
        s_ready = bus.req_ready;
        s_gv    = grant_valid;
        s_gid   = grant_id;
        s_state = int'(dut.state_q);
        @(posedge clk);
        #1;
        cyc++;
        if (s_wr) begin
            log_d.push_back(s_data);
            log_g.push_back(int'(s_gid));
            log_c.push_back(cyc);
            phead[s_gid]++;
        end
        drive();
    endtask

    task automatic run_until(input string tag, input int n, input int budget);
        int b = 0;
        while (log_d.size() < n && b < budget) begin
            tick();
            b++;
        end
        chk(tag, log_d.size(), n);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.fifo_full  = 1'b0;
        bus.fifo_rd_en = 1'b0;
        bus.fifo_empty = 1'b1;
        for (int i = 0; i < 4; i++) begin
            phead[i] = 0;
            ptail[i] = 0;
            pen[i]   = 1'b0;
        end
        log_d.delete();
        log_g.delete();
        log_c.delete();
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int ord [5];
    int viol;

    initial begin
        ord = '{0, 1, 2, 3, 0};
        do_reset();

        // Reset values
        chk("rst_gv",   int'(grant_valid), 0);
        chk("rst_gid",  int'(grant_id), 0);
        chk("rst_occ",  int'(occupancy), 0);
        chk("rst_af",   int'(almost_full), 0);
        chk("rst_rdy",  int'(bus.req_ready), 0);
        chk("rst_wr",   int'(bus.fifo_wr_en), 0);
        chk("rst_data", int'(bus.fifo_data_in), 0);

        // Single producer 1, six words, burst split by one IDLE cycle
        load(1, 6, 8'h10, 1'b1);
        drive();
        run_until("t1_wait5", 5, 40);
        chk("t1_occ5", int'(occupancy), 5);
        chk("t1_af5",  int'(almost_full), 0);
        run_until("t1_wait6", 6, 40);
        chk("t1_occ6", int'(occupancy), 6);
        chk("t1_af6",  int'(almost_full), 1);
        for (int k = 0; k < 6 && k < log_d.size(); k++) begin
            chk($sformatf("t1_data%0d", k), int'(log_d[k]), 8'h10 + k);
            chk($sformatf("t1_gid%0d", k), log_g[k], 1);
        end
        if (log_c.size() >= 5) begin
            chk("t1_b2b",  log_c[1] - log_c[0], 1);
            chk("t1_idle", log_c[4] - log_c[3], 2);
        end

        // All four producers valid: order 0,1,2,3,0, four writes each
        do_reset();
        load(0, 8, 8'h00, 1'b1);
        load(1, 4, 8'h10, 1'b1);
        load(2, 4, 8'h20, 1'b1);
        load(3, 4, 8'h30, 1'b1);
        drive();
        run_until("t2_wait", 20, 200);
        for (int b = 0; b < 5; b++) begin
            for (int k = 0; k < 4; k++) begin
                if (b*4 + k < log_d.size()) begin
                    chk($sformatf("t2_data%0d", b*4+k), int'(log_d[b*4+k]),
                        ord[b]*16 + ((b == 4) ? 4 : 0) + k);
                    chk($sformatf("t2_gid%0d", b*4+k), log_g[b*4+k], ord[b]);
                end
            end
        end
        chk("t2_occ_sat", int'(occupancy), 8);
        chk("t2_af",      int'(almost_full), 1);

        // Producer 2 stalled by fifo_full for three cycles after its second write
        do_reset();
        load(2, 4, 8'h20, 1'b1);
        drive();
        run_until("t3_wait2", 2, 20);
        bus.fifo_full = 1'b1;
        viol = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (s_wr || s_ready != 4'b0) viol++;
            if (i == 1) chk("t3_state", s_state, int'(STALL));
        end
        chk("t3_nowrite", viol, 0);
        bus.fifo_full = 1'b0;
        run_until("t3_wait4", 4, 20);
        for (int k = 0; k < 4 && k < log_d.size(); k++)
            chk($sformatf("t3_data%0d", k), int'(log_d[k]), 8'h20 + k);
        if (log_c.size() >= 4) chk("t3_resume", log_c[2] - log_c[1], 5);
        tick();
        chk("t3_release", int'(s_gv), 0);

        // Occupancy: write+read holds, read-only decrements, empty/zero saturate
        do_reset();
        load(0, 6, 8'h40, 1'b1);
        drive();
        run_until("t4_wait5", 5, 30);
        chk("t4_occ5", int'(occupancy), 5);
        bus.fifo_rd_en = 1'b1;
        bus.fifo_empty = 1'b0;
        tick();
        chk("t4_wr_rd", log_d.size(), 6);
        chk("t4_occ_hold", int'(occupancy), 5);
        tick();
        chk("t4_occ_dec", int'(occupancy), 4);
        do_reset();
        bus.fifo_rd_en = 1'b1;
        bus.fifo_empty = 1'b1;
        tick();
        chk("t4_rd_empty", int'(occupancy), 0);
        bus.fifo_empty = 1'b0;
        tick();
        chk("t4_rd_zero", int'(occupancy), 0);
        bus.fifo_rd_en = 1'b0;

        // Owner drops valid after one write; next in order after owner wins
        do_reset();
        load(1, 1, 8'hA1, 1'b1);
        load(0, 1, 8'hA0, 1'b0);
        load(3, 1, 8'hA3, 1'b0);
        drive();
        run_until("t5_wait1", 1, 20);
        pen[0] = 1'b1;
        pen[3] = 1'b1;
        drive();
        tick();
        chk("t5_nowr", int'(s_wr), 0);
        tick();
        chk("t5_release", int'(s_gv), 0);
        run_until("t5_wait2", 2, 20);
        if (log_d.size() >= 2) begin
            chk("t5_gid",  log_g[1], 3);
            chk("t5_data", int'(log_d[1]), 8'hA3);
        end

        // Asynchronous reset mid-burst at occupancy 3
        do_reset();
        load(0, 8, 8'h00, 1'b1);
        load(2, 8, 8'h20, 1'b1);
        drive();
        run_until("t6_wait3", 3, 20);
        chk("t6_occ3", int'(occupancy), 3);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_gv",   int'(grant_valid), 0);
        chk("t6_gid",  int'(grant_id), 0);
        chk("t6_occ",  int'(occupancy), 0);
        chk("t6_af",   int'(almost_full), 0);
        chk("t6_rdy",  int'(bus.req_ready), 0);
        chk("t6_wr",   int'(bus.fifo_wr_en), 0);
        chk("t6_data", int'(bus.fifo_data_in), 0);
        tick();
        tick();
        chk("t6_nowr_rst", log_d.size(), 3);
        rst = 1'b0;
        run_until("t6_wait4", 4, 20);
        if (log_d.size() >= 4) begin
            chk("t6_first_gid",  log_g[3], 0);
            chk("t6_first_data", int'(log_d[3]), 8'h03);
        end
        chk("t6_occ_after", int'(occupancy), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_rr_write_arbiter.md
Name: fifo_rr_write_arbiter

Overview:
- Shares one write port of the team's 8-deep, 8-bit synchronous FIFO between NUM_REQ producers.
- Uses round-robin arbitration with a bounded burst length per grant.
- Tracks FIFO occupancy locally from the write/read strobes and exports an occupancy count and an almost-full flag.
- Sits directly in front of the FIFO write side; the FIFO read side is untouched and only observed.

Parameters:
- NUM_REQ, 4, number of producers (2..8).
- DATA_W, 8, data width per producer and FIFO data width.
- DEPTH, 8, FIFO depth (power of two).
- BURST_MAX, 4, maximum consecutive writes per grant (>=1).
- AF_LEVEL, 6, occupancy at or above which almost_full is asserted.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-producer data valid.
- req_data  in  NUM_REQ*DATA_W  producer data, producer i at bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  per-producer accept, one-hot or zero.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_data_in  out  DATA_W  FIFO write data.
- fifo_full  in  1  FIFO full flag.
- fifo_rd_en  in  1  FIFO read strobe (monitor only).
- fifo_empty  in  1  FIFO empty flag.
- grant_valid  out  1  a producer currently owns the port.
- grant_id  out  $clog2(NUM_REQ)  owner index.
- occupancy  out  $clog2(DEPTH)+1  tracked FIFO fill level, 0..DEPTH.
- almost_full  out  1  registered, high when occupancy >= AF_LEVEL.

Behaviour:
- Reset values:
  - State IDLE.
  - grant_valid=0, grant_id=0, burst_cnt=0.
  - last_grant=NUM_REQ-1, so producer 0 wins first.
  - occupancy=0, almost_full=0.
  - req_ready=0, fifo_wr_en=0.
  - fifo_data_in=0 when no grant.
- Reset mid-burst aborts the burst immediately. No write is issued in the reset cycle.
- States IDLE, BURST, STALL.
- IDLE:
  - Search req_valid starting at last_grant+1 modulo NUM_REQ, wrapping, and take the first set bit.
  - On a hit, register grant_id, set grant_valid=1, clear burst_cnt, go to BURST.
  - No writes occur in IDLE; arbitration costs exactly one cycle.
- BURST:
  - req_ready[grant_id] = !fifo_full (combinational). All other ready bits are 0.
  - fifo_wr_en = req_valid[grant_id] & req_ready[grant_id].
  - fifo_data_in = req_data slice of grant_id. The data path is combinational, zero latency.
  - On each write, burst_cnt increments.
  - On a write with burst_cnt==BURST_MAX-1: set last_grant=grant_id, clear grant_valid, go to IDLE.
  - If req_valid[grant_id]==0: release the same way (last_grant=grant_id, grant_valid=0, IDLE), no write.
  - Else if fifo_full=1: go to STALL and keep the grant and burst_cnt.
- STALL:
  - req_ready=0, fifo_wr_en=0.
  - Return to BURST on the first cycle with fifo_full=0.
  - If the owner drops req_valid while stalled, release to IDLE as above.
- Occupancy:
  - wr = fifo_wr_en; rd = fifo_rd_en & !fifo_empty.
  - wr&!rd adds 1, rd&!wr subtracts 1, both or neither holds.
  - Saturates at DEPTH and at 0; the increment is never applied when occupancy==DEPTH.
- almost_full is registered from the next occupancy value, so it updates the same edge as occupancy.
- Fairness: a continuously valid producer waits at most (NUM_REQ-1)*(BURST_MAX+1) cycles for a grant, excluding stalls.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - the state enum (IDLE, BURST, STALL);
  - width constants derived from NUM_REQ/DEPTH;
  - the default BURST_MAX and AF_LEVEL.
- One sub-module, rr_pick: a combinational round-robin priority encoder. Inputs are the req vector and last_grant; outputs are hit and index.
- The FSM, burst counter and occupancy tracker stay in the top.

Test Plan:
- Single producer 1 valid with data 0x10..0x15 (6 words), BURST_MAX=4 → grant_id=1; writes 0x10-0x13, one IDLE cycle, writes 0x14-0x15; occupancy ends at 6 and almost_full=1 at that edge.
- All four producers continuously valid → grant order 0,1,2,3,0; each grant is exactly 4 writes; the FIFO content order matches.
- Producer 2 bursting, fifo_full forced high after its 2nd write for 3 cycles → state STALL, req_ready=0, no fifo_wr_en; it resumes with writes 3 and 4 and then releases.
- Simultaneous fifo_wr_en and a valid read with occupancy 5 → occupancy stays 5. A read with fifo_empty=1 at occupancy 0 → stays 0.
- Owner drops req_valid after 1 write → release next cycle; the next valid producer in round-robin order after the owner is granted.
- rst asserted mid-burst at occupancy 3 → all outputs return to reset values asynchronously; after release producer 0 (if valid) wins first.
